// File: rtl/result_writeback_pkg.sv
// Shared sizing constants and state encoding for the result writeback stage.
package result_writeback_pkg;

    localparam int ARRAYWIDTH          = 4;
    localparam int DATASIZE            = 8;
    localparam int OUTPUT_BUF_DATASIZE = 32;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_RUN  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/result_writeback_requant_lane.sv
// One lane of requantization: rounding arithmetic right shift, then signed
// saturation to the output width.
module requant_lane #(
    parameter int IW = 32,
    parameter int OW = 8
) (
    input  logic signed [IW-1:0] x,
    input  logic        [4:0]    shift,
    output logic        [OW-1:0] y
);

    localparam logic signed [IW:0] MAXV = $signed({{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [IW:0] MINV = ~MAXV;

    logic signed [IW:0] xe;
    logic signed [IW:0] rnd;
    logic signed [IW:0] r;
    logic signed [IW:0] q;

    // One guard bit keeps x + half-LSB from wrapping at the positive extreme.
    always_comb begin
        xe  = {x[IW-1], x};
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = {{IW{1'b0}}, 1'b1} << (shift - 5'd1);
        end
        r = xe + rnd;
        q = r >>> shift;
        if (q > MAXV) begin
            y = MAXV[OW-1:0];
        end else if (q < MINV) begin
            y = MINV[OW-1:0];
        end else begin
            y = q[OW-1:0];
        end
    end

endmodule

// File: rtl/result_writeback.sv
// Requantizes accelerator result rows, buffers them in a small FIFO and streams
// them out tagged with their row index; pulses done when the tile is delivered.
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int N     = ARRAYWIDTH,
    parameter int IW    = OUTPUT_BUF_DATASIZE,
    parameter int OW    = DATASIZE,
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   rows_total,
    input  logic [4:0]      shift,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*IW-1:0] in_row,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*OW-1:0] out_data,
    output logic [AW-1:0]   out_addr,
    output logic            done,
    output logic            overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = N * OW;
    localparam int EW = DW + AW;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    wb_state_t state_reg, state_next;

    logic [AW-1:0] total_reg;
    logic [AW-1:0] in_cnt_reg;
    logic [4:0]    shift_reg;
    logic          stg_valid_reg;
    logic [DW-1:0] stg_data_reg;
    logic [AW-1:0] stg_addr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [DW-1:0] last_data_reg;
    logic [AW-1:0] last_addr_reg;
    logic          overflow_reg;
    logic          done_reg;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [DW-1:0] lane_y;
    logic [CW:0]   occ;
    logic          accept, push, pop, last_pop, done_next;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            requant_lane #(.IW(IW), .OW(OW)) u_lane (
                .x     (in_row[gi*IW +: IW]),
                .shift (shift_reg),
                .y     (lane_y[gi*OW +: OW])
            );
        end
    endgenerate

    assign head     = mem[rd_ptr_reg];
    assign occ      = {1'b0, count_reg} + {{CW{1'b0}}, stg_valid_reg};
    assign push     = stg_valid_reg;
    assign pop      = out_valid && out_ready;
    assign last_pop = pop && (head[DW +: AW] == total_reg - AW'(1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= WB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WB_IDLE: if (start) state_next = WB_RUN;
            WB_RUN: begin
                if (start) begin
                    state_next = WB_RUN;
                end else if (last_pop) begin
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // Output logic; start takes priority over a same-cycle accept.
    always_comb begin
        in_ready  = (state_reg == WB_RUN) && (occ < DEPTH_C) && (in_cnt_reg < total_reg);
        accept    = in_valid && in_ready && !start;
        out_valid = (count_reg != '0);
        done_next = (state_reg == WB_RUN) && last_pop && !start;
        out_data  = out_valid ? head[DW-1:0] : last_data_reg;
        out_addr  = out_valid ? head[DW +: AW] : last_addr_reg;
        done      = done_reg;
        overflow  = overflow_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_reg     <= AW'(1);
            in_cnt_reg    <= '0;
            shift_reg     <= '0;
            stg_valid_reg <= 1'b0;
            stg_data_reg  <= '0;
            stg_addr_reg  <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            last_data_reg <= '0;
            last_addr_reg <= '0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else if (start) begin
            total_reg     <= (rows_total == '0) ? AW'(1) : rows_total;
            shift_reg     <= shift;
            in_cnt_reg    <= '0;
            stg_valid_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg      <= done_next;
            stg_valid_reg <= accept;
            if (in_valid && !in_ready) begin
                overflow_reg <= 1'b1;
            end
            if (accept) begin
                stg_data_reg <= lane_y;
                stg_addr_reg <= in_cnt_reg;
                in_cnt_reg   <= in_cnt_reg + AW'(1);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + PW'(1);
                last_data_reg <= head[DW-1:0];
                last_addr_reg <= head[DW +: AW];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Row storage carries the address tag alongside the data.
    always_ff @(posedge clk) begin
        if (push && !start) begin
            mem[wr_ptr_reg] <= {stg_addr_reg, stg_data_reg};
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
// Randomized and directed checks of result_writeback against a row-level model.
module tb_result_writeback;

    localparam int N     = 4;
    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   rows_total;
    logic [4:0]      shift;
    logic            in_valid;
    logic            in_ready;
    logic [N*IW-1:0] in_row;
    logic            out_valid;
    logic            out_ready;
    logic [N*OW-1:0] out_data;
    logic [AW-1:0]   out_addr;
    logic            done;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    // Model: rows accepted but not yet delivered, with the edge they were accepted on.
    logic [N*OW-1:0] q_data[$];
    int              q_addr[$];
    int              q_t[$];
    int m_total, m_shift, m_acc, m_pop, cyc;
    bit m_run, m_ovf, m_done;

    always #5 clk = ~clk;

    result_writeback #(.N(N), .IW(IW), .OW(OW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rows_total (rows_total),
        .shift      (shift),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .done       (done),
        .overflow   (overflow)
    );

    function automatic logic [OW-1:0] ref_lane(int x, int sh);
        longint r, hi, lo;
        hi = (longint'(1) << (OW - 1)) - 1;
        lo = -hi - 1;
        r  = longint'(x);
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return OW'(r);
    endfunction

    function automatic logic [N*OW-1:0] ref_row(logic [N*IW-1:0] row, int sh);
        logic [N*OW-1:0] res;
        res = '0;
        for (int k = 0; k < N; k++) begin
            res[k*OW +: OW] = ref_lane(int'($signed(row[k*IW +: IW])), sh);
        end
        return res;
    endfunction

    function automatic logic [N*IW-1:0] rand_row();
        logic [N*IW-1:0] row;
        logic [IW-1:0]   v;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = IW'($urandom_range(0, 4000)) - IW'(2000);
                default: v = ($urandom_range(0, 1) == 1 ? 32'h7FFF_FFFF : 32'h8000_0000) ^ IW'($urandom_range(0, 15));
            endcase
            row[k*IW +: IW] = v;
        end
        return row;
    endfunction

    function automatic bit m_ready();
        return m_run && ((m_acc - m_pop) < DEPTH) && (m_acc < m_total);
    endfunction

    function automatic bit m_valid();
        return (q_t.size() > 0) && (cyc >= q_t[0] + 1);
    endfunction

    task automatic model_reset();
        q_data.delete(); q_addr.delete(); q_t.delete();
        m_total = 1; m_shift = 0; m_acc = 0; m_pop = 0;
        m_run = 0; m_ovf = 0; m_done = 0;
    endtask

    // Advance one clock: update the model from the inputs about to be sampled.
    task automatic tick();
        bit er, ev;
        er = m_ready();
        ev = m_valid();
        m_done = 0;
        if (start) begin
            q_data.delete(); q_addr.delete(); q_t.delete();
            m_total = (rows_total == '0) ? 1 : int'(rows_total);
            m_shift = int'(shift);
            m_acc = 0; m_pop = 0; m_run = 1; m_ovf = 0;
        end else begin
            if (in_valid && !er) m_ovf = 1;
            if (in_valid && er) begin
                q_data.push_back(ref_row(in_row, m_shift));
                q_addr.push_back(m_acc);
                q_t.push_back(cyc + 1);
                m_acc++;
            end
            if (ev && out_ready) begin
                void'(q_data.pop_front()); void'(q_addr.pop_front()); void'(q_t.pop_front());
                m_pop++;
                if (m_pop == m_total) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_start(int total, int sh);
        start = 1'b1;
        rows_total = AW'(total);
        shift = 5'(sh);
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; in_valid = 0; out_ready = 0; in_row = '0; rows_total = '0; shift = '0;
        cyc = 0;
        model_reset();
        #2 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (in_ready !== 1'b0)  $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        if (in_ready !== 1'b0) failures++;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0)    begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_addr !== '0)    begin failures++; $display("FAIL reset_out_addr: got %h expected 0", out_addr); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b1;
        @(negedge clk);
        $display("reset: done, checks=%0d", checks);
    endtask

    task automatic test_lane_vectors();
        int            sh_t[8] = '{4, 0, 2, 31, 1, 3, 0, 5};
        int            x_t[8]  = '{296, 5000, -1000, 32'h7FFF_FFFF, -3, -4, -200, 16};
        logic [OW-1:0] y_t[8]  = '{8'h13, 8'h7F, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h80, 8'h01};
        logic [IW-1:0] xv;
        int            w;
        for (int i = 0; i < 8; i++) begin
            do_start(1, sh_t[i]);
            xv = IW'(x_t[i]);
            in_row = {N{xv}};
            in_valid = 1'b1;
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0;
            for (w = 0; w < 6 && out_valid !== 1'b1; w++) tick();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL lane_valid_timeout: vec %0d got out_valid=%b expected 1", i, out_valid);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (out_data[k*OW +: OW] !== y_t[i]) begin
                    failures++;
                    $display("FAIL lane_value: vec %0d lane %0d got %h expected %h", i, k, out_data[k*OW +: OW], y_t[i]);
                end
            end
            checks++; if (out_addr !== '0) begin failures++; $display("FAIL lane_addr: got %0d expected 0", out_addr); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL lane_done: got %b expected 1", done); end
            tick();
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL lane_done_width: got %b expected 0", done); end
            $display("lane vector %0d: shift=%0d x=%0d -> %h", i, sh_t[i], x_t[i], out_data[OW-1:0]);
        end
    endtask

    task automatic test_streaming();
        int acc_n = 0, pops = 0, dones = 0, first_acc = -1, first_val = -1, last_val = -1;
        do_start(6, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_row = rand_row();
            in_valid = (acc_n < 6);
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc_n++;
            end
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1) begin
                if (first_val < 0) first_val = cyc;
                last_val = cyc;
                checks++;
                if (out_addr !== AW'(pops) || q_data.size() == 0 || out_data !== q_data[0]) begin
                    failures++;
                    $display("FAIL stream_row: got addr %0d data %h expected addr %0d data %h",
                             out_addr, out_data, pops, q_data.size() > 0 ? q_data[0] : '0);
                end
                pops++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (pops != 6) begin failures++; $display("FAIL stream_count: got %0d rows expected 6", pops); end
        checks++; if (first_val - first_acc != 2) begin failures++; $display("FAIL stream_latency: got %0d expected 2", first_val - first_acc); end
        checks++; if (last_val - first_val != 5) begin failures++; $display("FAIL stream_throughput: got span %0d expected 5", last_val - first_val); end
        checks++; if (dones != 1) begin failures++; $display("FAIL stream_done_count: got %0d expected 1", dones); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL stream_overflow: got %b expected 0", overflow); end
        $display("streaming: rows=%0d latency=%0d done_pulses=%0d", pops, first_val - first_acc, dones);
    endtask

    // Runs (or continues) a tile with random valid/ready, checking every cycle.
    task automatic test_random_stream(int total, int sh, int vpct, int rpct, bit restart);
        bit seen_done = 0;
        int n = 0;
        if (restart) do_start(total, sh);
        for (int c = 0; c < 3000; c++) begin
            in_row = rand_row();
            in_valid = ($urandom_range(0, 99) < vpct);
            out_ready = ($urandom_range(0, 99) < rpct);
            checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_in_ready: cyc %0d got %b expected %b", cyc, in_ready, m_ready()); end
            checks++; if (out_valid !== m_valid()) begin failures++; $display("FAIL rnd_out_valid: cyc %0d got %b expected %b", cyc, out_valid, m_valid()); end
            if (m_valid()) begin
                checks++;
                if (out_data !== q_data[0] || out_addr !== AW'(q_addr[0])) begin
                    failures++;
                    $display("FAIL rnd_row: cyc %0d got addr %0d data %h expected addr %0d data %h",
                             cyc, out_addr, out_data, q_addr[0], q_data[0]);
                end
            end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow: cyc %0d got %b expected %b", cyc, overflow, m_ovf); end
            checks++; if (done !== m_done) begin failures++; $display("FAIL rnd_done: cyc %0d got %b expected %b", cyc, done, m_done); end
            if (m_done) begin
                seen_done = 1;
                break;
            end
            if (out_valid && out_ready) n++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (!seen_done) begin failures++; $display("FAIL rnd_timeout: got no done expected done within budget"); end
        $display("random tile: total=%0d shift=%0d rows_out=%0d", m_total, m_shift, n);
    endtask

    task automatic test_backpressure();
        int acc_n = 0;
        do_start(10, 3);
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_row = rand_row();
            in_valid = 1'b1;
            if (in_ready) acc_n++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (acc_n != 4) begin failures++; $display("FAIL bp_accepts: got %0d expected 4", acc_n); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b expected 1", overflow); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== AW'(i) || q_data.size() == 0 || out_data !== q_data[0]) begin
                failures++;
                $display("FAIL bp_drain: row %0d got valid %b addr %0d data %h expected addr %0d data %h",
                         i, out_valid, out_addr, out_data, i, q_data.size() > 0 ? q_data[0] : '0);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
        checks++; if (out_addr !== AW'(3)) begin failures++; $display("FAIL bp_hold_addr: got %0d expected 3", out_addr); end
        $display("backpressure: accepted=%0d before stall, drained in order", acc_n);
        test_random_stream(0, 0, 100, 100, 0);
    endtask

    task automatic test_restart();
        int dones = 0;
        do_start(3, 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_row = rand_row();
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL rs_pre: got valid %b overflow %b expected 1 1", out_valid, overflow); end
        do_start(5, 2);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rs_flush: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rs_overflow_clear: got %b expected 0", overflow); end
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL rs_no_done: got %0d pulses expected 0", dones); end
        in_row = rand_row();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_addr !== '0 || q_data.size() == 0 || out_data !== q_data[0]) begin
            failures++;
            $display("FAIL rs_first_row: got valid %b addr %0d data %h expected addr 0 data %h",
                     out_valid, out_addr, out_data, q_data.size() > 0 ? q_data[0] : '0);
        end
        $display("restart: flushed, new tile starts at addr %0d", out_addr);
        test_random_stream(0, 0, 80, 80, 0);
    endtask

    task automatic test_async_reset();
        do_start(8, 0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_row = rand_row();
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre: got %b expected 1", out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL ar_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0)    begin failures++; $display("FAIL ar_out_data: got %h expected 0", out_data); end
        checks++; if (out_addr !== '0)    begin failures++; $display("FAIL ar_out_addr: got %h expected 0", out_addr); end
        checks++; if (done !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL ar_flags: got done %b overflow %b expected 0 0", done, overflow); end
        model_reset();
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        $display("async reset: outputs cleared between edges");
        test_random_stream(5, 4, 80, 70, 1);
    endtask

    initial begin
        test_reset();
        test_lane_vectors();
        test_streaming();
        test_backpressure();
        test_restart();
        test_random_stream(0, 3, 60, 60, 1);
        test_random_stream(20, 7, 70, 60, 1);
        test_random_stream(12, 31, 90, 30, 1);
        test_random_stream(16, 0, 50, 90, 1);
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
